dut_test_scheduler: RTL



---
 rtl/dut_test_scheduler.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/dut_test_scheduler.sv
// dut_test_scheduler: walks an enabled-DUT mask in ascending order, selects
// each DUT, pulses its test start, waits for completion and records a
// per-DUT status and low-cycle count readable through RES_IDX.
// Optional feature macro: DUT_SCHED_TIMEOUT_EN enables the ack and run
// timeouts (statuses 10/11); without it the waits are unbounded.
module dut_test_scheduler #(
    parameter int unsigned NUM_DUT       = 5,
    parameter int unsigned CNT_WIDTH     = 32,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned ACK_TIMEOUT   = 16,
    parameter int unsigned RUN_TIMEOUT   = 1000000,
    localparam int unsigned SEL_W        = $clog2(NUM_DUT) + 1
) (
    input  logic                 CLK_SYS,
    input  logic                 RSTN,
    input  logic                 RUN,
    input  logic                 ABORT,
    input  logic [NUM_DUT-1:0]   DUT_MASK,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 DUT_DO_TEST,
    output logic [SEL_W-1:0]     DUT_SEL,
    input  logic                 DUT_RDY,
    input  logic [SEL_W-1:0]     RES_IDX,
    output logic [1:0]           RES_STATUS,
    output logic [CNT_WIDTH-1:0] RES_CYCLES
);

    localparam int unsigned SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [1:0] ST_PASS    = 2'b01;
    localparam logic [1:0] ST_RUN_TMO = 2'b10;
    localparam logic [1:0] ST_NO_ACK  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_SETTLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_NEXT,
        S_FINISH
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_DUT-1:0]     mask_q, mask_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [SETTLE_W-1:0]    settle_q, settle_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   abort_q, abort_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   start_q, start_d;
    logic [1:0]             status_q [NUM_DUT];
    logic [1:0]             status_d [NUM_DUT];
    logic [CNT_WIDTH-1:0]   cycles_q [NUM_DUT];
    logic [CNT_WIDTH-1:0]   cycles_d [NUM_DUT];
    logic [1:0]             res_status_q, res_status_d;
    logic [CNT_WIDTH-1:0]   res_cycles_q, res_cycles_d;

    logic [SEL_W-1:0]       low_idx_c;
    logic                   low_found_c;
    logic                   abort_pend_c;
    logic                   settle_done_c;
    logic [CNT_WIDTH-1:0]   cnt_inc_c;
    logic                   wr_en_c;
    logic [1:0]             wr_status_c;
    logic [CNT_WIDTH-1:0]   wr_cycles_c;

`ifdef DUT_SCHED_TIMEOUT_EN
    localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);
    logic [ACK_W-1:0]       ack_q, ack_d;
`else
    logic [CNT_WIDTH-1:0]   unused_tmo;
    assign unused_tmo = CNT_WIDTH'(ACK_TIMEOUT) ^ CNT_WIDTH'(RUN_TIMEOUT);
`endif

    assign abort_pend_c  = abort_q | ABORT;
    assign settle_done_c = (settle_q == SETTLE_W'(SETTLE_CYCLES - 1));
    assign cnt_inc_c     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // Lowest still-pending DUT index in the latched mask
    always_comb begin
        low_idx_c   = '0;
        low_found_c = 1'b0;
        for (int i = int'(NUM_DUT) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx_c   = SEL_W'(i);
                low_found_c = 1'b1;
            end
        end
    end

    // Batch sequencing: next state, counters, result writes, output lookahead
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        sel_d       = sel_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        abort_d     = abort_pend_c;
        status_d    = status_q;
        cycles_d    = cycles_q;
        wr_en_c     = 1'b0;
        wr_status_c = '0;
        wr_cycles_c = '0;
`ifdef DUT_SCHED_TIMEOUT_EN
        ack_d       = ack_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (RUN) begin
                    mask_d = DUT_MASK;
                    for (int i = 0; i < int'(NUM_DUT); i++) begin
                        status_d[i] = '0;
                        cycles_d[i] = '0;
                    end
                    state_d = (DUT_MASK == '0) ? S_FINISH : S_SCAN;
                end
            end
            S_SCAN: begin
                if (low_found_c) begin
                    sel_d    = low_idx_c;
                    settle_d = '0;
                    state_d  = S_SETTLE;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_SETTLE: begin
                if (abort_pend_c) begin
                    state_d = S_FINISH;
                end else if (settle_done_c) begin
                    if (DUT_RDY) begin
                        state_d = S_START;
                    end
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            S_START: begin
                cnt_d   = '0;
`ifdef DUT_SCHED_TIMEOUT_EN
                ack_d   = '0;
`endif
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // The edge that first sees RDY low already counts as a low cycle
                if (!DUT_RDY) begin
                    cnt_d   = CNT_WIDTH'(1);
                    state_d = S_WAIT_DONE;
                end
`ifdef DUT_SCHED_TIMEOUT_EN
                else if (ack_q == ACK_W'(ACK_TIMEOUT - 1)) begin
                    wr_en_c     = 1'b1;
                    wr_status_c = ST_NO_ACK;
                    state_d     = S_NEXT;
                end else begin
                    ack_d = ack_q + ACK_W'(1);
                end
`endif
            end
            S_WAIT_DONE: begin
                if (DUT_RDY) begin
                    wr_en_c     = 1'b1;
                    wr_status_c = ST_PASS;
                    wr_cycles_c = cnt_q;
                    state_d     = S_NEXT;
                end else begin
`ifdef DUT_SCHED_TIMEOUT_EN
                    if (cnt_inc_c >= CNT_WIDTH'(RUN_TIMEOUT)) begin
                        wr_en_c     = 1'b1;
                        wr_status_c = ST_RUN_TMO;
                        wr_cycles_c = CNT_WIDTH'(RUN_TIMEOUT);
                        state_d     = S_NEXT;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
`else
                    cnt_d = cnt_inc_c;
`endif
                end
            end
            S_NEXT: begin
                for (int i = 0; i < int'(NUM_DUT); i++) begin
                    if (sel_q == SEL_W'(i)) begin
                        mask_d[i] = 1'b0;
                    end
                end
                state_d = abort_pend_c ? S_FINISH : S_SCAN;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        for (int i = 0; i < int'(NUM_DUT); i++) begin
            if (wr_en_c && (sel_q == SEL_W'(i))) begin
                status_d[i] = wr_status_c;
                cycles_d[i] = wr_cycles_c;
            end
        end

        busy_d  = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d  = (state_d == S_FINISH);
        start_d = (state_d == S_START);
    end

    // Registered result read port; out-of-range indices read as 00/0
    always_comb begin
        res_status_d = '0;
        res_cycles_d = '0;
        for (int i = 0; i < int'(NUM_DUT); i++) begin
            if (RES_IDX == SEL_W'(i)) begin
                res_status_d = status_q[i];
                res_cycles_d = cycles_q[i];
            end
        end
    end

    // State and output registers
    always_ff @(posedge CLK_SYS or negedge RSTN) begin
        if (!RSTN) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            sel_q        <= '0;
            settle_q     <= '0;
            cnt_q        <= '0;
            abort_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            start_q      <= 1'b0;
            res_status_q <= '0;
            res_cycles_q <= '0;
            for (int i = 0; i < int'(NUM_DUT); i++) begin
                status_q[i] <= '0;
                cycles_q[i] <= '0;
            end
`ifdef DUT_SCHED_TIMEOUT_EN
            ack_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            sel_q        <= sel_d;
            settle_q     <= settle_d;
            cnt_q        <= cnt_d;
            abort_q      <= abort_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            start_q      <= start_d;
            res_status_q <= res_status_d;
            res_cycles_q <= res_cycles_d;
            for (int i = 0; i < int'(NUM_DUT); i++) begin
                status_q[i] <= status_d[i];
                cycles_q[i] <= cycles_d[i];
            end
`ifdef DUT_SCHED_TIMEOUT_EN
            ack_q        <= ack_d;
`endif
        end
    end

    assign BUSY        = busy_q;
    assign DONE        = done_q;
    assign DUT_DO_TEST = start_q;
    assign DUT_SEL     = sel_q;
    assign RES_STATUS  = res_status_q;
    assign RES_CYCLES  = res_cycles_q;

endmodule
